// File: rtl/key_cnt_pkg.sv
// Shared types and width helpers for the key event counter.
package key_cnt_pkg;

  typedef enum logic [1:0] {
    REL     = 2'd0,
    REL_CHK = 2'd1,
    PRS     = 2'd2,
    PRS_CHK = 2'd3
  } db_state_e;

  // Bits needed to hold values 0..v-1 (minimum 1)
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned     r;
    longint unsigned x;
    r = 32'd0;
    x = 64'd1;
    while (x < 64'(v)) begin
      x = x << 1;
      r = r + 32'd1;
    end
    return (r == 32'd0) ? 32'd1 : r;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned DB_CYC_DEF  = 500000;
  localparam int unsigned REP_DLY_DEF = 25000000;
  localparam int unsigned REP_PER_DEF = 5000000;
  localparam int unsigned DB_W        = clog2(DB_CYC_DEF + 32'd1);
  localparam int unsigned REP_W       = clog2(max2(REP_DLY_DEF, REP_PER_DEF) + 32'd1);

endpackage

// File: rtl/key_debounce.sv
// One key channel: 2-FF synchroniser, debounce FSM, optional hold-repeat timer.
// Optional feature macro: HOLD_REPEAT_EN (auto-repeat while the key is held).
// o_event_c is combinational so the counter in the parent updates on the
// same edge that the FSM accepts the press.
module key_debounce
  import key_cnt_pkg::*;
#(
  parameter int unsigned DB_CYC  = 500000,
  parameter int unsigned REP_DLY = 25000000,
  parameter int unsigned REP_PER = 5000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_stable,
  output logic o_event_c
);

  localparam int unsigned CW = clog2(DB_CYC + 32'd1);

  logic          r_sync1;
  logic          r_sync2;
  db_state_e     r_state;
  db_state_e     w_state_nxt;
  logic [CW-1:0] r_db_cnt;
  logic [CW-1:0] w_db_cnt_nxt;
  logic          r_stable;
  logic          w_stable_nxt;
  logic          w_press_c;

  // Synchroniser, preset to released so reset never looks like a press
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state, debounce counter and stable level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= REL;
      r_db_cnt <= '0;
      r_stable <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_db_cnt <= w_db_cnt_nxt;
      r_stable <= w_stable_nxt;
    end
  end

  // Next state; the entry cycle into a CHK state counts as the first stable sample
  always_comb begin
    w_state_nxt  = r_state;
    w_db_cnt_nxt = r_db_cnt;
    w_stable_nxt = r_stable;
    w_press_c    = 1'b0;
    case (r_state)
      REL: begin
        if (!r_sync2) begin
          if (DB_CYC == 32'd1) begin
            w_state_nxt  = PRS;
            w_stable_nxt = 1'b1;
            w_press_c    = 1'b1;
          end else begin
            w_state_nxt  = REL_CHK;
            w_db_cnt_nxt = CW'(1);
          end
        end
      end
      REL_CHK: begin
        if (r_sync2) begin
          w_state_nxt = REL;
        end else if (r_db_cnt == CW'(DB_CYC - 32'd1)) begin
          w_state_nxt  = PRS;
          w_stable_nxt = 1'b1;
          w_press_c    = 1'b1;
        end else begin
          w_db_cnt_nxt = r_db_cnt + CW'(1);
        end
      end
      PRS: begin
        if (r_sync2) begin
          if (DB_CYC == 32'd1) begin
            w_state_nxt  = REL;
            w_stable_nxt = 1'b0;
          end else begin
            w_state_nxt  = PRS_CHK;
            w_db_cnt_nxt = CW'(1);
          end
        end
      end
      PRS_CHK: begin
        if (!r_sync2) begin
          w_state_nxt = PRS;
        end else if (r_db_cnt == CW'(DB_CYC - 32'd1)) begin
          w_state_nxt  = REL;
          w_stable_nxt = 1'b0;
        end else begin
          w_db_cnt_nxt = r_db_cnt + CW'(1);
        end
      end
      default: w_state_nxt = REL;
    endcase
  end

`ifdef HOLD_REPEAT_EN
  localparam int unsigned RW = clog2(max2(REP_DLY, REP_PER) + 32'd1);

  logic [RW-1:0] r_rep_cnt;
  logic [RW-1:0] w_rep_cnt_nxt;
  logic          r_rep_on;
  logic          w_rep_on_nxt;
  logic          w_rep_c;

  // Repeat timer: first repeat REP_DLY after press, then every REP_PER while held
  always_comb begin
    w_rep_cnt_nxt = r_rep_cnt;
    w_rep_on_nxt  = r_rep_on;
    w_rep_c       = 1'b0;
    if (r_state == PRS || r_state == PRS_CHK) begin
      if (!r_rep_on && r_rep_cnt == RW'(REP_DLY - 32'd1)) begin
        w_rep_c       = 1'b1;
        w_rep_on_nxt  = 1'b1;
        w_rep_cnt_nxt = '0;
      end else if (r_rep_on && r_rep_cnt == RW'(REP_PER - 32'd1)) begin
        w_rep_c       = 1'b1;
        w_rep_cnt_nxt = '0;
      end else begin
        w_rep_cnt_nxt = r_rep_cnt + RW'(1);
      end
    end else begin
      w_rep_cnt_nxt = '0;
      w_rep_on_nxt  = 1'b0;
    end
  end

  // Repeat timer registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rep_cnt <= '0;
      r_rep_on  <= 1'b0;
    end else begin
      r_rep_cnt <= w_rep_cnt_nxt;
      r_rep_on  <= w_rep_on_nxt;
    end
  end

  assign o_event_c = w_press_c | w_rep_c;
`else
  localparam int unsigned unused_rep_cfg = REP_DLY + REP_PER;

  assign o_event_c = w_press_c;
`endif

  assign o_stable = r_stable;

endmodule

// File: rtl/key_event_counter.sv
// Multi-channel debounced push-button event counter with modulo up/down counts.
// Optional feature macro: HOLD_REPEAT_EN (auto-repeat while a key is held).
module key_event_counter
  import key_cnt_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned MOD     = 5000000,
  parameter int unsigned DB_CYC  = 500000,
  parameter int unsigned REP_DLY = 25000000,
  parameter int unsigned REP_PER = 5000000
) (
  input  logic                 iCLK_50,
  input  logic                 iRST_N,
  input  logic [NCH-1:0]       iKEY,
  input  logic [NCH-1:0]       iDIR,
  input  logic [NCH-1:0]       iCLR,
  output logic [NCH*CNT_W-1:0] oCNT,
  output logic [NCH-1:0]       oPRESS,
  output logic [NCH-1:0]       oWRAP,
  output logic [NCH-1:0]       oSTABLE
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MOD - 32'd1);

  logic [NCH-1:0] w_event;
  logic [NCH-1:0] w_stable;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             r_wrap;

    key_debounce #(
      .DB_CYC  (DB_CYC),
      .REP_DLY (REP_DLY),
      .REP_PER (REP_PER)
    ) u_db (
      .i_clk     (iCLK_50),
      .i_rst_n   (iRST_N),
      .i_key_n   (iKEY[k]),
      .o_stable  (w_stable[k]),
      .o_event_c (w_event[k])
    );

    // Modulo up/down counter; clear wins over a same-cycle event
    always_ff @(posedge iCLK_50 or negedge iRST_N) begin
      if (!iRST_N) begin
        r_cnt   <= '0;
        r_press <= 1'b0;
        r_wrap  <= 1'b0;
      end else begin
        r_press <= w_event[k];
        r_wrap  <= 1'b0;
        if (iCLR[k]) begin
          r_cnt <= '0;
        end else if (w_event[k]) begin
          if (!iDIR[k]) begin
            if (r_cnt == CNT_MAX) begin
              r_cnt  <= '0;
              r_wrap <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else begin
            if (r_cnt == '0) begin
              r_cnt  <= CNT_MAX;
              r_wrap <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
      end
    end

    assign oCNT[k*CNT_W +: CNT_W] = r_cnt;
    assign oPRESS[k]              = r_press;
    assign oWRAP[k]               = r_wrap;
  end

  assign oSTABLE = w_stable;

endmodule
